// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier with a start/busy/done handshake.
// Optional feature macro: SHIFT_ADD_MULT_ZERO_BYPASS_EN (zero operands finish after one RUN cycle).

module RCAgen (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // 8-bit ripple-carry chain, one full adder per bit
  always_comb begin : ripple
    logic carry;
    carry = cin;
    sum   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module rca_generic #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Same ripple structure as RCAgen for widths other than 8
  always_comb begin : ripple
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH:0]     acc_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] product_r;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH-1:0]   add_sum_s;
  logic               add_cout_s;
  logic [WIDTH:0]     step_s;
  logic               last_s;
  logic               zero_hit_s;

  generate
    if (WIDTH == 8) begin : g_rca8
      RCAgen u_rca (
        .a    (acc_r[WIDTH-1:0]),
        .b    (mcand_r),
        .cin  (1'b0),
        .sum  (add_sum_s),
        .cout (add_cout_s)
      );
    end else begin : g_rcan
      rca_generic #(.WIDTH(WIDTH)) u_rca (
        .a    (acc_r[WIDTH-1:0]),
        .b    (mcand_r),
        .cin  (1'b0),
        .sum  (add_sum_s),
        .cout (add_cout_s)
      );
    end
  endgenerate

  // Conditional add for the current multiplier bit; acc_r[WIDTH] is always zero after a shift
  always_comb begin
    step_s = {acc_r[WIDTH], acc_r[WIDTH-1:0]};
    if (mplier_r[0]) begin
      step_s = {add_cout_s, add_sum_s};
    end else begin
      step_s = {acc_r[WIDTH], acc_r[WIDTH-1:0]};
    end
  end

  // Final RUN step detection, plus the optional early exit for zero operands
  always_comb begin
    last_s = (cnt_r == CNT_LAST);
`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
    zero_hit_s = (cnt_r == {CW{1'b0}}) &&
                 ((mcand_r == {WIDTH{1'b0}}) || (mplier_r == {WIDTH{1'b0}}));
`else
    zero_hit_s = 1'b0;
`endif
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (zero_hit_s || last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Datapath: operand capture, add-and-shift steps, product update on entry to DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_r   <= {WIDTH{1'b0}};
      acc_r     <= {(WIDTH+1){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= x;
            mplier_r <= y;
            acc_r    <= {(WIDTH+1){1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        RUN: begin
          acc_r    <= {1'b0, step_s[WIDTH:1]};
          mplier_r <= {step_s[0], mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (zero_hit_s) begin
            product_r <= {(2*WIDTH){1'b0}};
          end else if (last_s) begin
            product_r <= {step_s, mplier_r[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: expected products queued at start, popped on done.
module tb_shift_add_mult;

  localparam int LAT = 8;
`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 8;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  shift_add_mult #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    x = a;
    y = b;
    start = 1'b1;
    exp_q.push_back({8'd0, a} * {8'd0, b});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int k, output bit to);
    k = 0;
    to = 1'b0;
    while (done !== 1'b1) begin
      if (k >= 40) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0;
    x = 8'd0;
    y = 8'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
        errors++;
        $display("FAIL reset_idle busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
      end
    end
  endtask

  task automatic test_max;
    int k;
    bit to;
    logic [15:0] e;
    start_op(8'd255, 8'd255);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL max_busy_rise got %b want 1", busy);
    end
    wait_done(k, to);
    checks++;
    if (to || k != LAT) begin
      errors++;
      $display("FAIL max_latency got %0d (timeout=%0d) want %0d", k, to, LAT);
    end
    e = exp_q.pop_front();
    checks++;
    if (product !== e || e !== 16'hFE01) begin
      errors++;
      $display("FAIL max_product got %h want %h", product, 16'hFE01);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL max_release done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] vals [9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd127, 8'd128, 8'd129, 8'd254, 8'd255};
    int k;
    bit to;
    logic [15:0] e;
    logic [7:0] a;
    logic [7:0] b;
    int lat;
    for (int n = 0; n < 81 + 300; n++) begin
      if (n < 81) begin
        a = vals[n / 9];
        b = vals[n % 9];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      lat = (a == 8'd0 || b == 8'd0) ? LAT_ZERO : LAT;
      start_op(a, b);
      wait_done(k, to);
      e = exp_q.pop_front();
      checks++;
      if (to || k != lat || product !== e) begin
        errors++;
        $display("FAIL sweep %0d*%0d got %h after %0d want %h after %0d", a, b, product, k, e, lat);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL sweep_release %0d*%0d done=%b busy=%b want 0 0", a, b, done, busy);
      end
    end
  endtask

  task automatic test_zero;
    int k;
    bit to;
    logic [15:0] e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) start_op(8'd0, 8'd77);
      else        start_op(8'd77, 8'd0);
      wait_done(k, to);
      e = exp_q.pop_front();
      checks++;
      if (to || k != LAT_ZERO || product !== e) begin
        errors++;
        $display("FAIL zero_%0d got %h after %0d want %h after %0d", i, product, k, e, LAT_ZERO);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_release_%0d done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_ignore;
    int k;
    int k2;
    bit to;
    logic [15:0] e;
    start_op(8'd13, 8'd11);
    repeat (3) @(negedge clk);
    x = 8'd200;
    y = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k2, to);
    k = 4 + k2;
    e = exp_q.pop_front();
    checks++;
    if (to || k != LAT || product !== e || e !== 16'd143) begin
      errors++;
      $display("FAIL ignore_run got %0d after %0d want 143 after %0d", product, k, LAT);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'd143) begin
      errors++;
      $display("FAIL ignore_done done=%b busy=%b product=%0d want 0 0 143", done, busy, product);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || product !== 16'd143) begin
      errors++;
      $display("FAIL ignore_idle busy=%b product=%0d want 0 143", busy, product);
    end
    start_op(8'd200, 8'd3);
    wait_done(k, to);
    e = exp_q.pop_front();
    checks++;
    if (to || k != LAT || product !== e || e !== 16'h0258) begin
      errors++;
      $display("FAIL ignore_later got %h after %0d want 0258 after %0d", product, k, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int k;
    bit to;
    bit seen;
    logic [15:0] e;
    start_op(8'd170, 8'd85);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_quiet activity=%0d product=%h want 0 0000", seen, product);
    end
    start_op(8'd2, 8'd3);
    wait_done(k, to);
    e = exp_q.pop_front();
    checks++;
    if (to || k != LAT || product !== e || e !== 16'd6) begin
      errors++;
      $display("FAIL reset_mid_fresh got %0d after %0d want 6 after %0d", product, k, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int k;
    bit to;
    logic [15:0] e;
    @(negedge clk);
    x = 8'd9;
    y = 8'd7;
    start = 1'b1;
    exp_q.push_back(16'd63);
    @(negedge clk);
    wait_done(k, to);
    e = exp_q.pop_front();
    checks++;
    if (to || k != LAT || product !== e) begin
      errors++;
      $display("FAIL b2b_first got %0d after %0d want %0d after %0d", product, k, e, LAT);
    end
    x = 8'd250;
    y = 8'd251;
    exp_q.push_back({8'd0, x} * {8'd0, y});
    @(negedge clk);
    wait_done(k, to);
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (to || k != LAT + 1 || product !== e) begin
      errors++;
      $display("FAIL b2b_second got %0d after %0d want %0d after %0d", product, k, e, LAT + 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_release done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_sweep();
    test_zero();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
